// File: rtl/servo_sequencer_if.sv
// Host write port of the servo sequencer: position writes into the shadow
// registers over a valid/ready handshake, plus the bad-channel error pulse.
interface servo_sequencer_if #(
    parameter int N   = 8,
    parameter int NCH = 4
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    logic            wr_valid_i;
    logic            wr_ready_o;
    logic [CH_W-1:0] wr_ch_i;
    logic [N-1:0]    wr_pos_i;
    logic            wr_err_o;

    modport master (
        output wr_valid_i,
        output wr_ch_i,
        output wr_pos_i,
        input  wr_ready_o,
        input  wr_err_o
    );

    modport slave (
        input  wr_valid_i,
        input  wr_ch_i,
        input  wr_pos_i,
        output wr_ready_o,
        output wr_err_o
    );
endinterface

// File: rtl/servo_sequencer.sv
// Multi-channel servo frame scheduler. One shared frame/slot timer walks the
// channels in order, each getting a fixed 2 ms slot; the pulse width comes
// from an active register that is reloaded from the host shadow only at frame
// start, so a write never disturbs a frame already in progress.
module servo_sequencer #(
    parameter int CLK_PER_NS = 40,
    parameter int N          = 8,
    parameter int NCH        = 4,
    parameter int FRAME_MS   = 20
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           run_i,
    input  logic [NCH-1:0] en_i,
    output logic           frame_start_o,
    output logic [NCH-1:0] srv_o,
    servo_sequencer_if.slave wr
);
    localparam int MS_CYC    = 1_000_000 / CLK_PER_NS;
    localparam int STEP_CYC  = MS_CYC >> N;
    localparam int SLOT_CYC  = 2 * MS_CYC;
    localparam int FRAME_CYC = FRAME_MS * MS_CYC;
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SLOT_W    = $clog2(SLOT_CYC);
    localparam int FRAME_W   = $clog2(FRAME_CYC);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOT_CYC - 1);
    localparam logic [SLOT_W-1:0]  BASE_LAST  = SLOT_W'(MS_CYC - 1);
    localparam logic [SLOT_W-1:0]  STEP       = SLOT_W'(STEP_CYC);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_CYC - 1);
    localparam logic [CH_W-1:0]    CH_LAST    = CH_W'(NCH - 1);
    localparam logic [N-1:0]       POS_MID    = N'(1) << (N - 1);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, TAIL} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic [FRAME_W-1:0]  w_frame_nxt;
    logic [SLOT_W-1:0]   r_slot_cnt;
    logic [SLOT_W-1:0]   w_slot_nxt;
    logic [CH_W-1:0]     r_ch_idx;
    logic [CH_W-1:0]     w_ch_nxt;
    logic [N-1:0]        r_shadow [NCH];
    logic [N-1:0]        r_active [NCH];
    logic [N-1:0]        w_pos;
    logic [SLOT_W-1:0]   w_width_last;
    logic [NCH-1:0]      w_srv_nxt;
    logic [NCH-1:0]      r_srv;
    logic                r_frame_start;
    logic                r_wr_err;
    logic                w_load;
    logic                w_xfer;
    logic                w_bad_ch;
    logic                w_slot_end;
    logic                w_pulse_end;
    logic                w_frame_end;

    // A frame starts either from IDLE or at the very end of the TAIL period;
    // writes are held off in that cycle so the shadow copy is coherent.
    assign w_frame_end = (r_frame_cnt >= FRAME_LAST);
    assign w_slot_end  = (r_slot_cnt == SLOT_LAST);
    assign w_pulse_end = (r_slot_cnt == w_width_last);
    assign w_load      = run_i && ((r_state == IDLE) || ((r_state == TAIL) && w_frame_end));
    assign w_xfer      = wr.wr_valid_i && !w_load;
    assign w_bad_ch    = (32'(wr.wr_ch_i) >= 32'(NCH));

    assign wr.wr_ready_o = !w_load;
    assign wr.wr_err_o   = r_wr_err;
    assign srv_o         = r_srv;
    assign frame_start_o = r_frame_start;

    // Last pulse cycle of the current channel: MS_CYC + pos*STEP_CYC cycles long.
    always_comb begin
        w_pos = r_active[0];
        for (int k = 0; k < NCH; k++) begin
            if (r_ch_idx == CH_W'(k)) begin
                w_pos = r_active[k];
            end
        end
        w_width_last = BASE_LAST + SLOT_W'(w_pos) * STEP;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping run_i aborts the frame from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (!run_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = PULSE;
                PULSE:   if (w_pulse_end) w_state_nxt = GAP;
                GAP:     if (w_slot_end) w_state_nxt = (r_ch_idx < CH_LAST) ? PULSE : TAIL;
                TAIL:    if (w_frame_end) w_state_nxt = PULSE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Next values of the frame, slot and channel counters.
    always_comb begin
        w_frame_nxt = r_frame_cnt;
        w_slot_nxt  = r_slot_cnt;
        w_ch_nxt    = r_ch_idx;
        if (!run_i || w_load) begin
            w_frame_nxt = '0;
            w_slot_nxt  = '0;
            w_ch_nxt    = '0;
        end else begin
            case (r_state)
                PULSE: begin
                    w_frame_nxt = r_frame_cnt + FRAME_W'(1);
                    w_slot_nxt  = r_slot_cnt + SLOT_W'(1);
                end
                GAP: begin
                    w_frame_nxt = r_frame_cnt + FRAME_W'(1);
                    if (w_slot_end) begin
                        w_slot_nxt = '0;
                        if (r_ch_idx < CH_LAST) begin
                            w_ch_nxt = r_ch_idx + CH_W'(1);
                        end
                    end else begin
                        w_slot_nxt = r_slot_cnt + SLOT_W'(1);
                    end
                end
                TAIL: begin
                    w_frame_nxt = r_frame_cnt + FRAME_W'(1);
                    w_slot_nxt  = '0;
                end
                default: begin
                    w_frame_nxt = '0;
                    w_slot_nxt  = '0;
                    w_ch_nxt    = '0;
                end
            endcase
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frame_cnt <= '0;
            r_slot_cnt  <= '0;
            r_ch_idx    <= '0;
        end else begin
            r_frame_cnt <= w_frame_nxt;
            r_slot_cnt  <= w_slot_nxt;
            r_ch_idx    <= w_ch_nxt;
        end
    end

    // Output decode from the upcoming state so srv_o lines up with the slot timer.
    always_comb begin
        w_srv_nxt = '0;
        if (w_state_nxt == PULSE) begin
            for (int k = 0; k < NCH; k++) begin
                if (w_ch_nxt == CH_W'(k)) begin
                    w_srv_nxt[k] = en_i[k];
                end
            end
        end
    end

    // Registered servo outputs and the frame-start pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_srv         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_srv         <= w_srv_nxt;
            r_frame_start <= w_load;
        end
    end

    // Shadow writes from the host, and the shadow-to-active copy at frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_err <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                r_shadow[k] <= POS_MID;
                r_active[k] <= POS_MID;
            end
        end else begin
            r_wr_err <= w_xfer && w_bad_ch;
            for (int k = 0; k < NCH; k++) begin
                if (w_xfer && !w_bad_ch && (wr.wr_ch_i == CH_W'(k))) begin
                    r_shadow[k] <= wr.wr_pos_i;
                end
                if (w_load) begin
                    r_active[k] <= r_shadow[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_servo_sequencer.sv
// Bench for servo_sequencer: a 4-channel and a 3-channel instance at
// 1 us clock, N=2, 20 ms frames (slot 2000 cycles, frame 20000 cycles).
module tb_servo_sequencer;
    typedef struct {
        int frame;
        int ch;
        int rise;
        int width;
    } frameExp_t;

    typedef struct {
        logic [1:0] ch;
        logic [1:0] pos;
        logic       expErr;
    } wrVec_t;

    logic       clk = 1'b0;
    logic       rst4, rst3, run4, run3;
    logic [3:0] en4;
    logic [2:0] en3;
    logic       fs4, fs3;
    logic [3:0] srv4;
    logic [2:0] srv3;
    int         cyc = 0;
    int         nTotal = 0;
    int         nBad = 0;
    int         mRise [4];
    int         mWidth [4];
    int         mMulti;
    int         mFsExtra;
    int         cycA;
    frameExp_t  fexp [20];
    wrVec_t     wvec [4];

    servo_sequencer_if #(.N(2), .NCH(4)) bus4 ();
    servo_sequencer_if #(.N(2), .NCH(3)) bus3 ();

    servo_sequencer #(.CLK_PER_NS(1000), .N(2), .NCH(4), .FRAME_MS(20)) dut4 (
        .clk_i(clk), .rst_i(rst4), .run_i(run4), .en_i(en4),
        .frame_start_o(fs4), .srv_o(srv4), .wr(bus4)
    );

    servo_sequencer #(.CLK_PER_NS(1000), .N(2), .NCH(3), .FRAME_MS(20)) dut3 (
        .clk_i(clk), .rst_i(rst3), .run_i(run3), .en_i(en3),
        .frame_start_o(fs3), .srv_o(srv3), .wr(bus3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        nTotal++;
        if (act != exp) begin
            nBad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One write through the handshake; returns wr_err_o in the cycle after the transfer and the one after that.
    task automatic applyStimulus(input int sel, input logic [1:0] ch, input logic [1:0] pos,
                                 output logic errA, output logic errB);
        int   guard = 0;
        logic rdy;
        if (sel == 0) begin
            bus4.wr_valid_i = 1'b1; bus4.wr_ch_i = ch; bus4.wr_pos_i = pos;
        end else begin
            bus3.wr_valid_i = 1'b1; bus3.wr_ch_i = ch; bus3.wr_pos_i = pos;
        end
        #1;
        rdy = (sel == 0) ? bus4.wr_ready_o : bus3.wr_ready_o;
        while (!rdy && guard < 10) begin
            @(negedge clk); #1;
            rdy = (sel == 0) ? bus4.wr_ready_o : bus3.wr_ready_o;
            guard++;
        end
        checkOutput("write_accepted", int'(rdy), 1);
        @(negedge clk);
        errA = (sel == 0) ? bus4.wr_err_o : bus3.wr_err_o;
        bus4.wr_valid_i = 1'b0;
        bus3.wr_valid_i = 1'b0;
        @(negedge clk);
        errB = (sel == 0) ? bus4.wr_err_o : bus3.wr_err_o;
    endtask

    // Samples len cycles starting at the current negedge (offset 0 = frame start).
    task automatic measureFrame(input int len, input int sel);
        logic [3:0] s;
        logic       f;
        for (int k = 0; k < 4; k++) begin
            mRise[k] = -1;
            mWidth[k] = 0;
        end
        mMulti = 0;
        mFsExtra = 0;
        for (int o = 0; o < len; o++) begin
            s = (sel == 0) ? srv4 : {1'b0, srv3};
            f = (sel == 0) ? fs4 : fs3;
            if ($countones(s) > 1) mMulti++;
            if (o > 0 && f) mFsExtra++;
            for (int k = 0; k < 4; k++) begin
                if (s[k]) begin
                    if (mRise[k] < 0) mRise[k] = o;
                    mWidth[k]++;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic compareFrame(input int id);
        for (int i = 0; i < 20; i++) begin
            if (fexp[i].frame == id) begin
                checkOutput($sformatf("f%0d_ch%0d_rise", id, fexp[i].ch), mRise[fexp[i].ch], fexp[i].rise);
                checkOutput($sformatf("f%0d_ch%0d_width", id, fexp[i].ch), mWidth[fexp[i].ch], fexp[i].width);
            end
        end
        checkOutput($sformatf("f%0d_one_hot", id), mMulti, 0);
        checkOutput($sformatf("f%0d_fs_once", id), mFsExtra, 0);
    endtask

    task automatic waitFrameStart(input int sel, input int limit);
        int   g = 0;
        logic f;
        f = (sel == 0) ? fs4 : fs3;
        while (!f && g < limit) begin
            @(negedge clk);
            f = (sel == 0) ? fs4 : fs3;
            g++;
        end
        checkOutput("frame_start_seen", int'(f), 1);
    endtask

    initial begin
        logic eA, eB;

        // frames: 0=A 1=B 2=C(en 1101) 3=rerun partial, 4=NCH3 pre-reset, 5=NCH3 post-reset
        fexp[0]  = '{0, 0, 0, 1500};    fexp[1]  = '{0, 1, 2000, 1500};
        fexp[2]  = '{0, 2, 4000, 1500}; fexp[3]  = '{0, 3, 6000, 1500};
        fexp[4]  = '{1, 0, 0, 1500};    fexp[5]  = '{1, 1, 2000, 1500};
        fexp[6]  = '{1, 2, 4000, 1750}; fexp[7]  = '{1, 3, 6000, 1000};
        fexp[8]  = '{2, 0, 0, 1250};    fexp[9]  = '{2, 1, -1, 0};
        fexp[10] = '{2, 2, 4000, 1750}; fexp[11] = '{2, 3, 6000, 1000};
        fexp[12] = '{3, 0, 0, 1250};    fexp[13] = '{3, 1, -1, 0};
        fexp[14] = '{4, 0, 0, 1000};    fexp[15] = '{4, 1, 2000, 1750};
        fexp[16] = '{4, 2, 4000, 500};  fexp[17] = '{5, 0, 0, 1500};
        fexp[18] = '{5, 1, 2000, 1500}; fexp[19] = '{5, 2, 4000, 1500};

        wvec[0] = '{2'd0, 2'd0, 1'b0};
        wvec[1] = '{2'd2, 2'd2, 1'b0};
        wvec[2] = '{2'd3, 2'd1, 1'b1};
        wvec[3] = '{2'd1, 2'd3, 1'b0};

        rst4 = 1'b1; rst3 = 1'b1; run4 = 1'b0; run3 = 1'b0;
        en4 = 4'hF; en3 = 3'h7;
        bus4.wr_valid_i = 1'b0; bus4.wr_ch_i = '0; bus4.wr_pos_i = '0;
        bus3.wr_valid_i = 1'b0; bus3.wr_ch_i = '0; bus3.wr_pos_i = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_srv4", int'(srv4), 0);
        checkOutput("rst_fs4", int'(fs4), 0);
        checkOutput("rst_err4", int'(bus4.wr_err_o), 0);
        checkOutput("rst_srv3", int'(srv3), 0);
        checkOutput("rst_err3", int'(bus3.wr_err_o), 0);
        checkOutput("idle_ready4", int'(bus4.wr_ready_o), 1);

        rst4 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        checkOutput("idle_srv4", int'(srv4), 0);
        run4 = 1'b1;
        #1;
        checkOutput("ready_low_in_load", int'(bus4.wr_ready_o), 0);
        @(negedge clk);
        checkOutput("fs_after_load", int'(fs4), 1);
        checkOutput("ch0_up_at_start", int'(srv4), 1);
        cycA = cyc;

        $display("[TB] frames A..C with mid-frame and load-cycle writes");
        fork
            begin
                measureFrame(20000, 0);
                compareFrame(0);
                checkOutput("fs_period_AB", int'(fs4), 1);
                measureFrame(20000, 0);
                compareFrame(1);
                checkOutput("fs_period_BC", int'(fs4), 1);
                en4 = 4'b1101;
                measureFrame(20000, 0);
                compareFrame(2);
                checkOutput("fs_period_CD", int'(fs4), 1);
            end
            begin
                int g = 0;
                repeat (100) @(negedge clk);
                applyStimulus(0, 2'd2, 2'd3, eA, eB);
                applyStimulus(0, 2'd3, 2'd0, eA, eB);
                while ((cyc - cycA) != 19999 && g < 30000) begin
                    @(negedge clk);
                    g++;
                end
                checkOutput("sync_load_offset", cyc - cycA, 19999);
                bus4.wr_valid_i = 1'b1; bus4.wr_ch_i = 2'd0; bus4.wr_pos_i = 2'd1;
                #1;
                checkOutput("ready_low_frame_load", int'(bus4.wr_ready_o), 0);
                @(negedge clk); #1;
                checkOutput("ready_after_frame_load", int'(bus4.wr_ready_o), 1);
                @(negedge clk);
                bus4.wr_valid_i = 1'b0;
            end
        join

        $display("[TB] run drop mid-pulse and rerun");
        en4 = 4'hF;
        repeat (500) @(negedge clk);
        checkOutput("ch0_high_before_drop", int'(srv4), 1);
        run4 = 1'b0;
        @(negedge clk);
        checkOutput("srv_after_drop", int'(srv4), 0);
        checkOutput("no_fs_after_drop", int'(fs4), 0);
        begin
            int act = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (fs4 || srv4 != 4'b0) act++;
            end
            checkOutput("idle_quiet", act, 0);
        end
        run4 = 1'b1;
        #1;
        checkOutput("ready_low_rerun_load", int'(bus4.wr_ready_o), 0);
        @(negedge clk);
        checkOutput("fs_rerun", int'(fs4), 1);
        measureFrame(2000, 0);
        compareFrame(3);

        $display("[TB] NCH=3 writes, bad channel, reset mid-pulse");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, wvec[i].ch, wvec[i].pos, eA, eB);
            checkOutput($sformatf("err_v%0d", i), int'(eA), int'(wvec[i].expErr));
            checkOutput($sformatf("err_clear_v%0d", i), int'(eB), 0);
        end
        run3 = 1'b1;
        @(negedge clk);
        checkOutput("fs3_after_load", int'(fs3), 1);
        measureFrame(4500, 1);
        compareFrame(4);
        checkOutput("ch2_high_before_rst", int'(srv3), 4);
        rst3 = 1'b1;
        @(negedge clk);
        checkOutput("srv3_after_rst", int'(srv3), 0);
        checkOutput("fs3_after_rst", int'(fs3), 0);
        @(negedge clk);
        rst3 = 1'b0;
        waitFrameStart(1, 10);
        measureFrame(6000, 1);
        compareFrame(5);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end
endmodule
